bx_hit_tagger: RTL and testbench

- Upstream stage of the bunch-counter buffer. Keeps the LHC bunch-crossing (BX) and orbit counters, synchronised by the BC0 orbit marker.
- Timestamps each incoming hit with the current BX and orbit, queues it, and writes 32-bit hit records into the downstream buffer.
- Never writes while the buffer reports full. Counts hits it has to drop and flags them in the record stream.

---
 rtl/bx_hit_tagger.sv | 142 ++++++++++++++
 tb/tb_bx_hit_tagger.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bx_hit_tagger.sv
// Bunch-crossing / orbit counters plus a small hit queue that stamps each hit
// with its BX and orbit and streams 32-bit records into a downstream buffer.
module bx_hit_tagger #(
    parameter int BX_MAX      = 3563,
    parameter int QUEUE_DEPTH = 4,
    parameter int QUEUE_AW    = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bc0,
    input  logic                  hit_valid,
    input  logic [7:0]            hit_ch,
    input  logic                  full,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [11:0]           bx_count,
    output logic [15:0]           orbit_count,
    output logic [15:0]           drop_count,
    output logic                  bx_err
);

    localparam logic [11:0]         BX_LAST = 12'(BX_MAX);
    localparam logic [QUEUE_AW:0]   Q_FULL  = (QUEUE_AW+1)'(QUEUE_DEPTH);
    localparam logic [QUEUE_AW:0]   Q_ONE   = (QUEUE_AW+1)'(1);

    logic [11:0]           bx_q, bx_d;
    logic [15:0]           orbit_q, orbit_d;
    logic [15:0]           drop_q, drop_d;
    logic                  bx_err_q, bx_err_d;
    logic                  first_bc0_q, first_bc0_d;
    logic                  ovf_q, ovf_d;
    logic [QUEUE_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [QUEUE_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QUEUE_AW:0]     cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [DATA_WIDTH-1:0] mem_q [QUEUE_DEPTH];

    logic                  q_empty, q_full, pop, push, drop;
    logic [DATA_WIDTH-1:0] record;

    assign q_empty = (cnt_q == '0);
    assign q_full  = (cnt_q == Q_FULL);
    assign pop     = !q_empty && !full;
    // A pop frees a slot this very edge, so a full queue can still accept.
    assign push    = hit_valid && (!q_full || pop);
    assign drop    = hit_valid && !push;
    assign record  = {orbit_q[7:0], bx_q, hit_ch, bx_err_q, ovf_q, 2'b00};

    always_comb begin
        bx_d        = bx_q + 12'd1;
        orbit_d     = orbit_q;
        bx_err_d    = bx_err_q;
        first_bc0_d = first_bc0_q;
        if (bc0 || bx_q == BX_LAST) begin
            bx_d    = '0;
            orbit_d = orbit_q + 16'd1;
        end
        if (bc0) begin
            first_bc0_d = 1'b0;
            // The very first marker only aligns the counter; it cannot be misaligned.
            if (!first_bc0_q) begin
                bx_err_d = (bx_q != BX_LAST);
            end
        end
    end

    always_comb begin
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        we_d     = pop;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (push) begin
            ovf_d = 1'b0;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            data_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + Q_ONE;
            2'b01:   cnt_d = cnt_q - Q_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bx_q        <= '0;
            orbit_q     <= '0;
            drop_q      <= '0;
            bx_err_q    <= 1'b0;
            first_bc0_q <= 1'b1;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            bx_q        <= bx_d;
            orbit_q     <= orbit_d;
            drop_q      <= drop_d;
            bx_err_q    <= bx_err_d;
            first_bc0_q <= first_bc0_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            data_q      <= data_d;
        end
    end

    // Storage carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= record;
        end
    end

    assign write_enable = we_q;
    assign data_out     = data_q;
    assign bx_count     = bx_q;
    assign orbit_count  = orbit_q;
    assign drop_count   = drop_q;
    assign bx_err       = bx_err_q;

endmodule

// File: tb/tb_bx_hit_tagger.sv
// Directed bench for bx_hit_tagger: counter wrap, BC0 sync check, hit records,
// backpressure with drops, back-to-back push/pop and reset during a burst.
module tb_bx_hit_tagger;

    logic        clk = 1'b0;
    logic        rst;
    logic        bc0;
    logic        hit_valid;
    logic [7:0]  hit_ch;
    logic        full;
    logic        write_enable;
    logic [31:0] data_out;
    logic [11:0] bx_count;
    logic [15:0] orbit_count;
    logic [15:0] drop_count;
    logic        bx_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference BX/orbit counters tracked by the bench.
    int mbx  = 0;
    int morb = 0;

    logic [31:0] bp_rec [1:7];
    logic [31:0] pp_rec [0:9];
    logic [31:0] r;

    always #5 clk = ~clk;

    bx_hit_tagger dut (
        .clk          (clk),
        .rst          (rst),
        .bc0          (bc0),
        .hit_valid    (hit_valid),
        .hit_ch       (hit_ch),
        .full         (full),
        .write_enable (write_enable),
        .data_out     (data_out),
        .bx_count     (bx_count),
        .orbit_count  (orbit_count),
        .drop_count   (drop_count),
        .bx_err       (bx_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (bc0 || mbx == 3563) begin
                mbx  = 0;
                morb = (morb + 1) % 65536;
            end else begin
                mbx = mbx + 1;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] rec(input logic [7:0] ch, input logic err, input logic ovf);
        logic [15:0] o;
        logic [11:0] b;
        o = 16'(morb);
        b = 12'(mbx);
        return {o[7:0], b, ch, err, ovf, 2'b00};
    endfunction

    task automatic expect_write(input string tag, input logic [31:0] exp);
        $display("write %s: we=%0b data=%h expected %h", tag, write_enable, data_out, exp);
        check({tag, "_we"}, {31'd0, write_enable}, 32'd1);
        check({tag, "_data"}, data_out, exp);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_bx"}, {20'd0, bx_count}, 32'(mbx));
        check({tag, "_orbit"}, {16'd0, orbit_count}, 32'(morb));
    endtask

    initial begin
        rst = 1'b0; bc0 = 1'b0; hit_valid = 1'b0; hit_ch = 8'h00; full = 1'b0;
        #1;
        run(2);
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_drop", {16'd0, drop_count}, 32'd0);
        check("rst_err", {31'd0, bx_err}, 32'd0);
        check_counters("rst");
        rst = 1'b1;

        // Free-running wrap with no BC0
        run(3563);
        check("wrap_top_bx", {20'd0, bx_count}, 32'd3563);
        tick();
        check("wrap_bx", {20'd0, bx_count}, 32'd0);
        check("wrap_orbit", {16'd0, orbit_count}, 32'd1);
        check("wrap_err", {31'd0, bx_err}, 32'd0);
        $display("wrap: bx=%0d orbit=%0d", bx_count, orbit_count);

        // First BC0, aligned at BX 3563
        run(3563);
        bc0 = 1'b1; tick(); bc0 = 1'b0;
        check("bc0_first_err", {31'd0, bx_err}, 32'd0);
        check_counters("bc0_first");

        // Misaligned BC0 at BX 100
        run(100);
        bc0 = 1'b1; tick(); bc0 = 1'b0;
        check("sync_err_set", {31'd0, bx_err}, 32'd1);
        check("sync_bx", {20'd0, bx_count}, 32'd0);
        check("sync_orbit", {16'd0, orbit_count}, 32'd3);

        // A hit while the error is set carries bit 3
        hit_valid = 1'b1; hit_ch = 8'h55; tick(); hit_valid = 1'b0;
        tick();
        expect_write("err_hit", 32'h0300_0558);

        // Clean BC0 clears the error
        run(3563 - mbx);
        bc0 = 1'b1; tick(); bc0 = 1'b0;
        check("sync_err_clr", {31'd0, bx_err}, 32'd0);
        check_counters("sync_clr");

        // Single hit at BX 5, orbit 4
        run(5);
        hit_valid = 1'b1; hit_ch = 8'h2A; tick(); hit_valid = 1'b0;
        check("single_lat_we", {31'd0, write_enable}, 32'd0);
        tick();
        expect_write("single", 32'h0400_52A0);
        tick();
        check("single_we_off", {31'd0, write_enable}, 32'd0);

        // Backpressure: six hits into a four-deep queue
        full = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            hit_valid = 1'b1;
            hit_ch    = 8'(i);
            if (i <= 4) bp_rec[i] = rec(8'(i), 1'b0, 1'b0);
            tick();
        end
        hit_valid = 1'b0;
        tick();
        check("bp_drop", {16'd0, drop_count}, 32'd2);
        check("bp_we", {31'd0, write_enable}, 32'd0);
        full = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_write($sformatf("bp_ch%0d", i), bp_rec[i]);
        end
        tick();
        check("bp_drain_we", {31'd0, write_enable}, 32'd0);
        hit_valid = 1'b1; hit_ch = 8'h07;
        bp_rec[7] = rec(8'h07, 1'b0, 1'b1);
        tick(); hit_valid = 1'b0;
        tick();
        expect_write("ovf_ch7", bp_rec[7]);
        check("ovf_bit", {31'd0, data_out[2]}, 32'd1);

        // Continuous hits: push and pop every cycle
        for (int i = 0; i <= 10; i++) begin
            hit_valid = (i < 10);
            hit_ch    = 8'(8'h10 + i);
            if (i < 10) pp_rec[i] = rec(8'(8'h10 + i), 1'b0, 1'b0);
            tick();
            if (i >= 1) expect_write($sformatf("pp%0d", i - 1), pp_rec[i - 1]);
        end
        hit_valid = 1'b0;
        tick();
        check("pp_we_off", {31'd0, write_enable}, 32'd0);
        check("pp_drop", {16'd0, drop_count}, 32'd2);

        // Reset in the middle of a stalled burst
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hit_valid = 1'b1; hit_ch = 8'(8'hA0 + i); tick();
        end
        hit_valid = 1'b0;
        check("mid_data_before", {31'd0, (data_out != 32'd0)}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_we", {31'd0, write_enable}, 32'd0);
        check("mid_data", data_out, 32'd0);
        check("mid_bx", {20'd0, bx_count}, 32'd0);
        mbx = 0; morb = 0;
        tick();
        full = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post_we%0d", i), {31'd0, write_enable}, 32'd0);
        end
        check_counters("post");
        check("post_drop", {16'd0, drop_count}, 32'd0);
        check("post_err", {31'd0, bx_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
